// File: rtl/arb_req_pkg.sv
// Shared types and default sizing for the arbiter requester front end.
package arb_req_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } client_state_e;

    localparam int N_DEF         = 3;
    localparam int CNT_W_DEF     = 2;
    localparam int BURST_LEN_DEF = 2;

endpackage

// File: rtl/arb_requester_if.sv
// Job/grant bundle between job sources, the arbiter and the requester block.
interface arb_requester_if #(
    parameter int N = arb_req_pkg::N_DEF
);
    logic [N-1:0] job_push;
    logic [N-1:0] gnt;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] overflow;
    logic         busy;
    logic         err_proto;

    modport master (
        output job_push, gnt,
        input  req, done, overflow, busy, err_proto
    );

    modport slave (
        input  job_push, gnt,
        output req, done, overflow, busy, err_proto
    );
endinterface

// File: rtl/arb_req_client.sv
// One client: request FSM, pending-job counter, beat counter and sticky overflow flag.
module arb_req_client
    import arb_req_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic job_push_i,
    input  logic gnt_i,
    output logic req_o,
    output logic done_o,
    output logic overflow_o,
    output logic busy_o
);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    client_state_e     state_q;
    logic [CNT_W-1:0]  pending_q, pending_d;
    logic [BEAT_W-1:0] beat_q;
    logic              req_q, done_q, overflow_q;
    logic              beat, complete, ovf_set;

    // A grant only counts while our own request is up.
    assign beat     = req_q & gnt_i;
    assign complete = beat && (((state_q == WAIT) && (BURST_LEN == 1)) ||
                               ((state_q == XFER) && (beat_q == BEAT_W'(BURST_LEN - 1))));

    always_comb begin
        pending_d = pending_q;
        ovf_set   = 1'b0;
        if (job_push_i && !complete) begin
            if (&pending_q) ovf_set = 1'b1;
            else            pending_d = pending_q + CNT_W'(1);
        end else if (!job_push_i && complete) begin
            pending_d = pending_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            beat_q     <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_q | ovf_set;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((pending_q != '0) || job_push_i) begin
                        state_q <= WAIT;
                        req_q   <= 1'b1;
                        beat_q  <= '0;
                    end
                end
                WAIT: begin
                    if (complete) begin
                        state_q <= REL;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (beat) begin
                        state_q <= XFER;
                        beat_q  <= BEAT_W'(1);
                    end
                end
                XFER: begin
                    if (complete) begin
                        state_q <= REL;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (beat) begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                REL: begin
                    // A push landing during the release cycle also keeps us going.
                    if (pending_d != '0) begin
                        state_q <= WAIT;
                        req_q   <= 1'b1;
                        beat_q  <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_o      = req_q;
    assign done_o     = done_q;
    assign overflow_o = overflow_q;
    assign busy_o     = (pending_q != '0) || (state_q != IDLE);

endmodule

// File: rtl/arb_requester.sv
// Requester front end: N client FSMs, busy reduce and optional grant checker
// (enabled by defining ARB_REQ_GNT_CHECK_EN; otherwise err_proto is tied low).
module arb_requester
    import arb_req_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    arb_requester_if.slave bus
);
    logic [N-1:0] req_w, done_w, ovf_w, busy_w;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_client
            arb_req_client #(
                .CNT_W     (CNT_W),
                .BURST_LEN (BURST_LEN)
            ) u_client (
                .clk        (clk),
                .rst_n      (rst_n),
                .job_push_i (bus.job_push[gi]),
                .gnt_i      (bus.gnt[gi]),
                .req_o      (req_w[gi]),
                .done_o     (done_w[gi]),
                .overflow_o (ovf_w[gi]),
                .busy_o     (busy_w[gi])
            );
        end
    endgenerate

    assign bus.req      = req_w;
    assign bus.done     = done_w;
    assign bus.overflow = ovf_w;
    assign bus.busy     = |busy_w;

`ifdef ARB_REQ_GNT_CHECK_EN
    logic err_q, gnt_bad;

    // Flags a multi-hot grant or a grant to a client that is not requesting.
    assign gnt_bad = ((bus.gnt & (bus.gnt - N'(1))) != '0) || ((bus.gnt & ~req_w) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_q | gnt_bad;
    end

    assign bus.err_proto = err_q;
`else
    assign bus.err_proto = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester with a per-step expectation scoreboard.
module tb_arb_requester;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arb_requester_if #(.N(N)) bus ();

    arb_requester #(.N(N), .CNT_W(2), .BURST_LEN(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string        tag;
        logic [N-1:0] req;
        logic [N-1:0] done;
        logic [N-1:0] ovf;
        logic         busy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic err_exp;

    task automatic chk_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic step(input string tag, input logic [N-1:0] push, input logic [N-1:0] gnt,
                        input logic [N-1:0] ereq, input logic [N-1:0] edone,
                        input logic [N-1:0] eovf, input logic ebusy);
        exp_t e;
        bus.job_push = push;
        bus.gnt      = gnt;
        e.tag = tag; e.req = ereq; e.done = edone; e.ovf = eovf; e.busy = ebusy;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk_vec({e.tag, " req"},      bus.req,      e.req);
        chk_vec({e.tag, " done"},     bus.done,     e.done);
        chk_vec({e.tag, " overflow"}, bus.overflow, e.ovf);
        chk_bit({e.tag, " busy"},     bus.busy,     e.busy);
        $display("%-14s push=%b gnt=%b -> req=%b done=%b ovf=%b busy=%b",
                 e.tag, push, gnt, bus.req, bus.done, bus.overflow, bus.busy);
    endtask

    task automatic do_reset(input string tag);
        bus.job_push = '0;
        bus.gnt      = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_vec({tag, " req"},      bus.req,       '0);
        chk_vec({tag, " done"},     bus.done,      '0);
        chk_vec({tag, " overflow"}, bus.overflow,  '0);
        chk_bit({tag, " busy"},     bus.busy,      1'b0);
        chk_bit({tag, " err"},      bus.err_proto, 1'b0);
        $display("%-14s req=%b done=%b busy=%b err=%b", tag, bus.req, bus.done, bus.busy, bus.err_proto);
    endtask

    initial begin
`ifdef ARB_REQ_GNT_CHECK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        bus.job_push = '0;
        bus.gnt      = '0;
        repeat (2) @(posedge clk);
        do_reset("reset");

        // Single job, grant held
        step("single.push",  3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 1'b1);
        step("single.beat1", 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 1'b1);
        step("single.beat2", 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 1'b1);
        step("single.idle",  3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
        step("single.quiet", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

        // Grant stall on client 1
        step("stall.push",   3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 1'b1);
        step("stall.beat1",  3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 1'b1);
        step("stall.hold",   3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 1'b1);
        step("stall.beat2",  3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 1'b1);
        step("stall.idle",   3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

        // Overflow on client 2, then drain three jobs
        step("ovf.push1",    3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 1'b1);
        step("ovf.push2",    3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 1'b1);
        step("ovf.push3",    3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 1'b1);
        step("ovf.push4",    3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 1'b1);
        for (int j = 0; j < 3; j++) begin
            step($sformatf("ovf.j%0d.beat1", j), 3'b000, 3'b100, 3'b100, 3'b000, 3'b100, 1'b1);
            step($sformatf("ovf.j%0d.rel", j),   3'b000, 3'b100, 3'b000, 3'b100, 3'b100, 1'b1);
            if (j < 2)
                step($sformatf("ovf.j%0d.wait", j), 3'b000, 3'b100, 3'b100, 3'b000, 3'b100, 1'b1);
        end
        step("ovf.idle",     3'b000, 3'b100, 3'b000, 3'b000, 3'b100, 1'b0);
        step("ovf.sticky",   3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 1'b0);

        // Push on the completion edge of client 0
        step("pc.push",      3'b001, 3'b000, 3'b001, 3'b000, 3'b100, 1'b1);
        step("pc.beat1",     3'b000, 3'b001, 3'b001, 3'b000, 3'b100, 1'b1);
        step("pc.rel_push",  3'b001, 3'b001, 3'b000, 3'b001, 3'b100, 1'b1);
        step("pc.rewait",    3'b000, 3'b001, 3'b001, 3'b000, 3'b100, 1'b1);
        step("pc.beat1b",    3'b000, 3'b001, 3'b001, 3'b000, 3'b100, 1'b1);
        step("pc.rel2",      3'b000, 3'b001, 3'b000, 3'b001, 3'b100, 1'b1);
        step("pc.idle",      3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 1'b0);

        // Reset in the middle of a burst
        step("rst.push",     3'b001, 3'b000, 3'b001, 3'b000, 3'b100, 1'b1);
        step("rst.beat1",    3'b000, 3'b001, 3'b001, 3'b000, 3'b100, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_vec("rst.async req",  bus.req,      3'b000);
        chk_vec("rst.async ovf",  bus.overflow, 3'b000);
        chk_bit("rst.async busy", bus.busy,     1'b0);
        $display("%-14s req=%b ovf=%b busy=%b", "rst.async", bus.req, bus.overflow, bus.busy);
        bus.gnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("rst.after1",   3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
        step("rst.after2",   3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);

        // Grant protocol checker
        do_reset("reset2");
        step("chk.multihot", 3'b000, 3'b011, 3'b000, 3'b000, 3'b000, 1'b0);
        chk_bit("chk.err_set", bus.err_proto, err_exp);
        step("chk.clear",    3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        chk_bit("chk.err_sticky", bus.err_proto, err_exp);
        $display("%-14s err=%b", "chk.err", bus.err_proto);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
